seq_detector_param: RTL and testbench
=====================================

# seq_detector_param

Parametrised Moore sequence detector, the successor to the team's fixed 3-bit pattern detector. Detects a runtime-programmable bit pattern of length 1..MAX_LEN on a qualified serial input. Supports overlapping and non-overlapping modes and counts matches in a saturating counter. Sits on serial bitstream paths in the FSM library, driving one-cycle match pulses to downstream control logic.

## Interface
- MAX_LEN, 8, maximum pattern length in bits (≥2)
- CNT_W, 8, width of the match counter
- LEN_W, $clog2(MAX_LEN)+1, width of the length field (derived; do not override)

- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- din  in  1  serial data bit
- din_valid  in  1  din is sampled only when high
- cfg_load  in  1  one-cycle strobe to latch the configuration
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is the first bit received, bit [0] the last
- cfg_len  in  LEN_W  pattern length
- cfg_overlap  in  1  1 = overlapping matches, 0 = non-overlapping
- y  out  1  Moore match output, high for one cycle per match
- match_count  out  CNT_W  saturating count of matches
- cfg_err  out  1  sticky: last load had an illegal length

## Operation
- States: IDLE (unconfigured or rejected), FILL (fewer than len bits held since last clear), ARMED (history ≥ len), MATCH.
- y = (state == MATCH). No other state drives y high.
- Registers: hist[MAX_LEN-1:0] (hist[0] newest), fill (saturates at MAX_LEN), pat, len, ovl.
- On a valid sample: nhist = {hist[MAX_LEN-2:0], din}, nfill = min(fill+1, MAX_LEN).
- Match when nfill ≥ len and nhist[len-1:0] == pat[len-1:0]. Bits above len are ignored.
- On match: next state is MATCH and match_count increments, saturating at 2^CNT_W-1.
  - Overlap mode: keep nhist and nfill.
  - Non-overlap mode: fill ← 0, so the next match needs len fresh bits.
- No match: next state is ARMED if nfill ≥ len, else FILL.
- MATCH lasts exactly one cycle, then exits per the rule above.
- If the cycle spent in MATCH has a valid sample completing another match, the next state is MATCH again and y stays high.
- din_valid low: hist and fill hold, and the state leaves MATCH to ARMED, or to FILL if fill < len.
- cfg_load with 1 ≤ cfg_len ≤ MAX_LEN:
  - latch pat, len, ovl;
  - clear hist, fill and match_count;
  - cfg_err ← 0, state ← FILL.
- cfg_load with cfg_len = 0 or cfg_len > MAX_LEN: cfg_err ← 1, state ← IDLE, match_count ← 0.
- In IDLE, din is ignored.
- cfg_load together with din_valid: the load wins and that din is dropped.

## Timing
- Reset values: state IDLE, y=0, match_count=0, cfg_err=0, hist=0, fill=0, pat=0, len=0, ovl=0.
- Reset has priority over cfg_load and din_valid.
- Reset mid-stream discards all history and configuration; a fresh cfg_load is required.
- Latency: the sample that completes a pattern is captured at edge N. y is high in the cycle after edge N and falls at edge N+1 unless re-matched.
- match_count updates at the same edge as the state enters MATCH.
- The first match is possible len valid samples after a load (fill counted from 0).
- Configuration inputs are sampled only on cfg_load and may change freely otherwise.

## Structure
- Package seq_det_pkg holds:
  - the state enum (IDLE, FILL, ARMED, MATCH; 2-bit encoding);
  - a function computing the length mask for MAX_LEN.
- One sub-module, sat_counter (parameter W; inputs clk, reset, clr, inc; output q), provides match_count.
- The FSM, history shift register and comparator live in the top module.

## Test plan
- Load pat=3'b011, len=3, non-overlap; stream 0,0,1,1,1,0,1,1 (valid every cycle) -> y pulses after the 4th and 8th samples; match_count=2.
- Load pat=2'b11, len=2; stream 1,1,1,1.
  - Overlap -> three matches, with y high for three consecutive cycles; count 3.
  - Non-overlap -> y after the 2nd and 4th samples; count 2.
- Load pat=3'b101, len=3, overlap; stream 1,0,1 with din_valid low for 2 cycles between each bit -> one y pulse one cycle after the 3rd valid sample; y is not stretched by the gaps.
- Load cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1, y never asserts on any stream. A following legal load clears cfg_err.
- Build with CNT_W=2; load pat=1'b1, len=1, overlap; send 6 ones -> match_count reads 1,2,3,3,3,3.
- Assert reset for one cycle after 2 of 3 pattern bits, then send the remaining bit -> no match; state IDLE; all outputs 0 until a new load.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised sequence detector.
package seq_det_pkg;

    // Widest pattern the mask helper can describe.
    localparam int MASK_W = 64;

    // Detector states, 2-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        MATCH = 2'd3
    } state_e;

    // Ones in the low 'len' bit positions; callers truncate to their pattern width.
    function automatic logic [MASK_W-1:0] len_mask(input logic [31:0] len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (32'(i) < len) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + W'(1);
        end else begin
            q_d = q_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-programmable serial pattern of 1..MAX_LEN bits.
// History is a shift register (bit 0 newest); fill tracks how many bits are
// usable since the last clear so a match never spans a configuration load or,
// in non-overlap mode, a previous match.
module seq_detector_param #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               y,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    import seq_det_pkg::*;

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic               cfg_err_q, cfg_err_d;
    logic               y_q, y_d;

    logic [MAX_LEN-1:0] mask_s;
    logic [MAX_LEN-1:0] nhist_s;
    logic [LEN_W-1:0]   nfill_s;
    logic               hit_s;
    logic               cfg_ok_s;
    logic               cnt_clr_s;
    logic               cnt_inc_s;

    // Candidate history after this sample and the masked pattern comparison.
    always_comb begin
        mask_s   = MAX_LEN'(len_mask(32'(len_q)));
        nhist_s  = {hist_q[MAX_LEN-2:0], din};
        nfill_s  = (fill_q >= LEN_W'(MAX_LEN)) ? fill_q : (fill_q + LEN_W'(1));
        hit_s    = (nfill_s >= len_q) && (((nhist_s ^ pat_q) & mask_s) == '0);
        cfg_ok_s = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    end

    // Next-state, configuration and counter control; a load always wins over data.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        cfg_err_d = cfg_err_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;

        if (cfg_load) begin
            cnt_clr_s = 1'b1;
            if (cfg_ok_s) begin
                pat_d     = cfg_pattern;
                len_d     = cfg_len;
                ovl_d     = cfg_overlap;
                hist_d    = '0;
                fill_d    = '0;
                cfg_err_d = 1'b0;
                state_d   = FILL;
            end else begin
                cfg_err_d = 1'b1;
                state_d   = IDLE;
            end
        end else if (state_q == IDLE) begin
            // Unconfigured: data is ignored entirely.
            state_d = IDLE;
        end else if (din_valid) begin
            hist_d = nhist_s;
            if (hit_s) begin
                state_d   = MATCH;
                cnt_inc_s = 1'b1;
                fill_d    = ovl_q ? nfill_s : '0;
            end else begin
                fill_d  = nfill_s;
                state_d = (nfill_s >= len_q) ? ARMED : FILL;
            end
        end else begin
            // No sample: a match pulse ends, other states hold.
            if (state_q == MATCH) begin
                state_d = (fill_q >= len_q) ? ARMED : FILL;
            end else begin
                state_d = state_q;
            end
        end

        y_d = (state_d == MATCH) ? 1'b1 : 1'b0;
    end

    // State, history, configuration and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            hist_q    <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            len_q     <= '0;
            ovl_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            cfg_err_q <= cfg_err_d;
            y_q       <= y_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .q     (match_count)
    );

    assign y       = y_q;
    assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic,
// checked against a queue-based model of the received bit stream.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, din, din_valid, cfg_load, cfg_overlap;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               y, y2, cfg_err, cfg_err2;
    logic [7:0]         match_count;
    logic [1:0]         match_count2;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .y(y), .match_count(match_count), .cfg_err(cfg_err)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .y(y2), .match_count(match_count2), .cfg_err(cfg_err2)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: the bits received since the last clear, newest at the back.
    bit         m_cfg;
    bit         m_q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_hits;
    logic       m_y;
    logic       m_err;

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic step(input logic r, input logic ld, input logic v, input logic d,
                        input logic [7:0] p, input logic [3:0] l, input logic o);
        bit hit;
        reset = r; cfg_load = ld; din_valid = v; din = d;
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        @(posedge clk);
        if (r) begin
            m_cfg = 1'b0; m_q.delete(); m_hits = 0; m_y = 1'b0; m_err = 1'b0;
        end else if (ld) begin
            if (l >= 1 && l <= MAX_LEN) begin
                m_cfg = 1'b1; m_pat = p; m_len = int'(l); m_ovl = o; m_err = 1'b0;
            end else begin
                m_cfg = 1'b0; m_err = 1'b1;
            end
            m_q.delete(); m_hits = 0; m_y = 1'b0;
        end else if (m_cfg && v) begin
            m_q.push_back(d);
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            hit = (m_q.size() >= m_len);
            for (int k = 0; k < m_len; k++) begin
                if (hit && (m_q[m_q.size() - 1 - k] != m_pat[k])) hit = 1'b0;
            end
            m_y = hit;
            if (hit) begin
                m_hits++;
                if (!m_ovl) m_q.delete();
            end
        end else begin
            m_y = 1'b0;
        end
        #1;
    endtask

    // Load with random din/din_valid alongside: the load must win.
    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), p, l, o);
    endtask

    // Data cycle; configuration inputs wiggle to show they are ignored.
    task automatic send(input logic d, input logic v);
        step(1'b0, 1'b0, v, d, 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 4'd1, 1'b1);
        total++; if (y !== 1'b0) begin bad++; $display("FAIL reset_y got %b want 0", y); end
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", match_count); end
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", cfg_err); end
        send(1'b1, 1'b1);
        total++; if (y !== 1'b0) begin bad++; $display("FAIL reset_idle_y got %b want 0", y); end
    endtask

    task automatic test_nonoverlap();
        logic b[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic ey;
        load(8'b011, 4'd3, 1'b0);
        total++; if (match_count !== 8'd0) begin bad++; $display("FAIL nonovl_cnt0 got %0d want 0", match_count); end
        for (int i = 0; i < 8; i++) begin
            send(b[i], 1'b1);
            ey = (i == 3 || i == 7) ? 1'b1 : 1'b0;
            total++; if (y !== ey) begin bad++; $display("FAIL nonovl_y step %0d got %b want %b", i, y, ey); end
            total++; if (y !== m_y) begin bad++; $display("FAIL nonovl_model_y step %0d got %b want %b", i, y, m_y); end
        end
        total++; if (match_count !== 8'd2) begin bad++; $display("FAIL nonovl_cnt got %0d want 2", match_count); end
    endtask

    task automatic test_pair_11();
        logic ey;
        for (int o = 1; o >= 0; o--) begin
            load(8'b11, 4'd2, 1'(o));
            for (int i = 0; i < 4; i++) begin
                send(1'b1, 1'b1);
                ey = (o == 1) ? ((i >= 1) ? 1'b1 : 1'b0) : ((i == 1 || i == 3) ? 1'b1 : 1'b0);
                total++; if (y !== ey) begin bad++; $display("FAIL pair11_y ovl=%0d step %0d got %b want %b", o, i, y, ey); end
            end
            total++;
            if (match_count !== ((o == 1) ? 8'd3 : 8'd2)) begin
                bad++; $display("FAIL pair11_cnt ovl=%0d got %0d want %0d", o, match_count, (o == 1) ? 3 : 2);
            end
        end
    endtask

    task automatic test_gaps();
        logic b[3] = '{1'b1, 1'b0, 1'b1};
        logic ey;
        load(8'b101, 4'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(b[i], 1'b1);
            ey = (i == 2) ? 1'b1 : 1'b0;
            total++; if (y !== ey) begin bad++; $display("FAIL gaps_y bit %0d got %b want %b", i, y, ey); end
            for (int g = 0; g < 2; g++) begin
                send(1'($urandom_range(0, 1)), 1'b0);
                total++; if (y !== 1'b0) begin bad++; $display("FAIL gaps_stretch bit %0d gap %0d got %b want 0", i, g, y); end
            end
        end
        total++; if (match_count !== 8'd1) begin bad++; $display("FAIL gaps_cnt got %0d want 1", match_count); end
    endtask

    task automatic test_illegal();
        logic [3:0] lens[2] = '{4'd0, 4'd9};
        for (int j = 0; j < 2; j++) begin
            load(8'($urandom), lens[j], 1'($urandom_range(0, 1)));
            total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL illegal_err len=%0d got %b want 1", lens[j], cfg_err); end
            for (int i = 0; i < 10; i++) begin
                send(1'($urandom_range(0, 1)), 1'b1);
                total++; if (y !== 1'b0) begin bad++; $display("FAIL illegal_y len=%0d step %0d got %b want 0", lens[j], i, y); end
            end
            total++; if (match_count !== 8'd0) begin bad++; $display("FAIL illegal_cnt got %0d want 0", match_count); end
        end
        load(8'b1, 4'd1, 1'b1);
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL illegal_clear got %b want 0", cfg_err); end
    endtask

    task automatic test_saturation();
        logic [1:0] ec[6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        load(8'b1, 4'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            send(1'b1, 1'b1);
            total++; if (match_count2 !== ec[i]) begin bad++; $display("FAIL sat_cnt2 step %0d got %0d want %0d", i, match_count2, ec[i]); end
            total++; if (match_count !== 8'(i + 1)) begin bad++; $display("FAIL sat_cnt8 step %0d got %0d want %0d", i, match_count, i + 1); end
            total++; if (y2 !== 1'b1) begin bad++; $display("FAIL sat_y step %0d got %b want 1", i, y2); end
        end
    endtask

    task automatic test_reset_midstream();
        load(8'b011, 4'd3, 1'b0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1, 8'($urandom), 4'd3, 1'b0);
        for (int i = 0; i < 4; i++) begin
            send((i == 1) ? 1'b0 : 1'b1, 1'b1);
            total++; if (y !== 1'b0) begin bad++; $display("FAIL rstmid_y step %0d got %b want 0", i, y); end
            total++; if (match_count !== 8'd0) begin bad++; $display("FAIL rstmid_cnt step %0d got %0d want 0", i, match_count); end
            total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rstmid_err step %0d got %b want 0", i, cfg_err); end
        end
    endtask

    task automatic test_random();
        int sel;
        logic [3:0] l;
        for (int i = 0; i < 600; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom), 1'($urandom_range(0, 1)));
            end else if (sel < 8) begin
                if ($urandom_range(0, 9) == 0) l = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
                else l = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(5, 8)) : 4'($urandom_range(1, 4));
                load(8'($urandom), l, 1'($urandom_range(0, 1)));
            end else begin
                send(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
            end
            total++; if (y !== m_y) begin bad++; $display("FAIL rand_y cyc %0d got %b want %b", i, y, m_y); end
            total++; if (y2 !== m_y) begin bad++; $display("FAIL rand_y2 cyc %0d got %b want %b", i, y2, m_y); end
            total++; if (match_count !== 8'(sat(m_hits, 8))) begin bad++; $display("FAIL rand_cnt cyc %0d got %0d want %0d", i, match_count, sat(m_hits, 8)); end
            total++; if (match_count2 !== 2'(sat(m_hits, 2))) begin bad++; $display("FAIL rand_cnt2 cyc %0d got %0d want %0d", i, match_count2, sat(m_hits, 2)); end
            total++; if (cfg_err !== m_err || cfg_err2 !== m_err) begin bad++; $display("FAIL rand_err cyc %0d got %b/%b want %b", i, cfg_err, cfg_err2, m_err); end
        end
    endtask

    initial begin
        reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        m_cfg = 1'b0; m_pat = '0; m_len = 0; m_ovl = 1'b0; m_hits = 0; m_y = 1'b0; m_err = 1'b0;
        test_reset();
        test_nonoverlap();
        test_pair_11();
        test_gaps();
        test_illegal();
        test_saturation();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
